// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: array depth, address width,
// FSM state encoding and the load-length legality check.
package instr_mem_loader_pkg;

    localparam int DEF_MEM_BYTES = 128;
    localparam int DEF_ADDR_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic length_ok(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream, load control and instruction-array write port of the loader.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              LoadStart;
    logic [7:0]        LoadLength;
    logic              LoadAbort;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              MemWrEn;
    logic [ADDR_W-1:0] MemWrAddr;
    logic [7:0]        MemWrData;
    logic              CpuHold;
    logic              LoadDone;
    logic              LoadError;
    logic [7:0]        BytesLoaded;
    logic [7:0]        Checksum;

    modport master (
        output LoadStart, LoadLength, LoadAbort, ByteIn, ByteValid,
        input  ByteReady, MemWrEn, MemWrAddr, MemWrData, CpuHold,
               LoadDone, LoadError, BytesLoaded, Checksum
    );

    modport slave (
        input  LoadStart, LoadLength, LoadAbort, ByteIn, ByteValid,
        output ByteReady, MemWrEn, MemWrAddr, MemWrData, CpuHold,
               LoadDone, LoadError, BytesLoaded, Checksum
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams host bytes into the instruction array from address 0, holding the core
// for the whole load so fetch never observes a partial image.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                Clock,
    input  logic                Reset,
    instr_mem_loader_if.slave   bus
);

    state_t            state;
    logic [7:0]        length;
    logic [7:0]        count;
    logic [7:0]        checksum;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              hold;
    logic              done;
    logic              error;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            length   <= '0;
            count    <= '0;
            checksum <= '0;
            ready    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            hold     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.LoadStart) begin
                        if (length_ok(bus.LoadLength, MEM_BYTES)) begin
                            length   <= bus.LoadLength;
                            count    <= '0;
                            checksum <= '0;
                            error    <= 1'b0;
                            hold     <= 1'b1;
                            ready    <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Abort takes priority: the byte offered alongside it is refused.
                    if (bus.LoadAbort) begin
                        error <= 1'b1;
                        hold  <= 1'b0;
                        ready <= 1'b0;
                        state <= IDLE;
                    end else if (bus.ByteValid && ready) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= ADDR_W'(count);
                        wr_data  <= bus.ByteIn;
                        count    <= count + 8'd1;
                        checksum <= checksum ^ bus.ByteIn;
                        if (count == length - 8'd1) begin
                            ready <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Final write is on the bus this cycle; release the core only afterwards.
                    hold  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hold  <= 1'b0;
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ByteReady   = ready;
    assign bus.MemWrEn     = wr_en;
    assign bus.MemWrAddr   = wr_addr;
    assign bus.MemWrData   = wr_data;
    assign bus.CpuHold     = hold;
    assign bus.LoadDone    = done;
    assign bus.LoadError   = error;
    assign bus.BytesLoaded = count;
    assign bus.Checksum    = checksum;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_instr_mem_loader;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    instr_mem_loader_if #(.ADDR_W(16)) bus();

    instr_mem_loader #(.MEM_BYTES(128), .ADDR_W(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [7:0] count; logic [7:0] csum; } done_t;

    wr_t         wq[$];
    done_t       dq[$];
    wr_t         we;
    done_t       de;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [7:0]  mem_model [0:127];
    logic [7:0]  exp_addr = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start(input logic [7:0] len);
        bus.LoadStart  = 1'b1;
        bus.LoadLength = len;
        tick();
        bus.LoadStart  = 1'b0;
        exp_addr       = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wq.push_back('{addr: 16'(exp_addr), data: b});
        exp_addr++;
    endtask

    task automatic stream(input logic [7:0] b);
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        push_byte(b);
        tick();
        bus.ByteValid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.ByteReady, 0);
        check({tag, "_wren"},  bus.MemWrEn, 0);
        check({tag, "_addr"},  bus.MemWrAddr, 0);
        check({tag, "_data"},  bus.MemWrData, 0);
        check({tag, "_hold"},  bus.CpuHold, 0);
        check({tag, "_done"},  bus.LoadDone, 0);
        check({tag, "_err"},   bus.LoadError, 0);
        check({tag, "_cnt"},   bus.BytesLoaded, 0);
        check({tag, "_csum"},  bus.Checksum, 0);
    endtask

    always @(negedge Clock) begin
        if (bus.MemWrEn === 1'b1) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write",
                         bus.MemWrAddr, bus.MemWrData);
            end else begin
                we = wq.pop_front();
                check("wr_addr", bus.MemWrAddr, we.addr);
                check("wr_data", bus.MemWrData, we.data);
            end
            if (bus.MemWrAddr < 16'd128) mem_model[bus.MemWrAddr[6:0]] = bus.MemWrData;
        end
        if (bus.LoadDone === 1'b1) begin
            if (dq.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_done: actual LoadDone=1 required 0");
            end else begin
                de = dq.pop_front();
                check("done_count", bus.BytesLoaded, de.count);
                check("done_csum",  bus.Checksum, de.csum);
                check("done_hold",  bus.CpuHold, 1);
                check("done_ready", bus.ByteReady, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned sent;
        int unsigned cyc;

        bus.LoadStart  = 1'b0;
        bus.LoadLength = '0;
        bus.LoadAbort  = 1'b0;
        bus.ByteIn     = '0;
        bus.ByteValid  = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // 1: four bytes back-to-back
        start(8'd4);
        check("t1_hold", bus.CpuHold, 1);
        check("t1_ready", bus.ByteReady, 1);
        dq.push_back('{count: 8'd4, csum: 8'h08});
        stream(8'h12);
        stream(8'h34);
        stream(8'h56);
        stream(8'h78);
        check("t1_done_ready", bus.ByteReady, 0);
        check("t1_done_hold", bus.CpuHold, 1);
        tick();
        check("t1_release", bus.CpuHold, 0);
        check("t1_fetch0", {mem_model[0], mem_model[1]}, 16'h1234);
        check("t1_fetch2", {mem_model[2], mem_model[3]}, 16'h5678);
        tick();

        // 2: sparse bytes, LoadStart re-pulsed mid-load
        start(8'd2);
        dq.push_back('{count: 8'd2, csum: 8'h99});
        sent = 0;
        cyc  = 0;
        while (sent < 2 && cyc < 20) begin
            check("t2_hold", bus.CpuHold, 1);
            if (cyc == 3) begin
                bus.LoadStart  = 1'b1;
                bus.LoadLength = 8'd5;
            end
            if (cyc % 3 == 2) begin
                bus.ByteIn    = (sent == 0) ? 8'hA5 : 8'h3C;
                bus.ByteValid = 1'b1;
                push_byte(bus.ByteIn);
                sent++;
            end
            tick();
            bus.ByteValid = 1'b0;
            bus.LoadStart = 1'b0;
            cyc++;
        end
        check("t2_done_hold", bus.CpuHold, 1);
        tick();
        check("t2_release", bus.CpuHold, 0);
        tick();
        tick();
        check("t2_idle_ready", bus.ByteReady, 0);
        check("t2_idle_hold", bus.CpuHold, 0);

        // 3: illegal lengths
        start(8'd0);
        check("t3_len0_err", bus.LoadError, 1);
        check("t3_len0_ready", bus.ByteReady, 0);
        check("t3_len0_hold", bus.CpuHold, 0);
        tick();
        check("t3_len0_wren", bus.MemWrEn, 0);
        start(8'd129);
        check("t3_len129_err", bus.LoadError, 1);
        check("t3_len129_ready", bus.ByteReady, 0);
        check("t3_len129_hold", bus.CpuHold, 0);
        tick();
        check("t3_len129_wren", bus.MemWrEn, 0);

        // 4: full 128-byte image; a byte offered in DONE must be refused
        start(8'd128);
        check("t4_err_cleared", bus.LoadError, 0);
        check("t4_ready", bus.ByteReady, 1);
        dq.push_back('{count: 8'h80, csum: 8'h80});
        for (int k = 0; k < 128; k++) stream(8'(k + 1));
        check("t4_done_ready", bus.ByteReady, 0);
        bus.ByteIn    = 8'hFF;
        bus.ByteValid = 1'b1;
        tick();
        bus.ByteValid = 1'b0;
        check("t4_release", bus.CpuHold, 0);
        check("t4_idle_ready", bus.ByteReady, 0);
        check("t4_last_byte", mem_model[127], 8'h80);
        tick();

        // 5: abort together with the third byte
        start(8'd4);
        stream(8'h11);
        stream(8'h22);
        bus.ByteIn    = 8'h33;
        bus.ByteValid = 1'b1;
        bus.LoadAbort = 1'b1;
        tick();
        bus.ByteValid = 1'b0;
        bus.LoadAbort = 1'b0;
        check("t5_err", bus.LoadError, 1);
        check("t5_hold", bus.CpuHold, 0);
        check("t5_ready", bus.ByteReady, 0);
        check("t5_count", bus.BytesLoaded, 2);
        check("t5_csum", bus.Checksum, 8'h33);
        tick();
        tick();

        // 6: reset mid-load, then a one-byte load
        start(8'd3);
        stream(8'h77);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("t6_reset");
        start(8'd1);
        dq.push_back('{count: 8'd1, csum: 8'hC3});
        stream(8'hC3);
        tick();
        check("t6_csum_held", bus.Checksum, 8'hC3);
        check("t6_count_held", bus.BytesLoaded, 1);
        check("t6_hold", bus.CpuHold, 0);

        tick();
        tick();
        check("wq_drained", wq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
